// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage and the data memory.
//   master (MEM stage): drives dmem_req/we/addr/wdata/be, receives dmem_ready/rdata
//   slave  (memory)   : the reverse
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                  input  dmem_ready, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                  output dmem_ready, dmem_rdata);
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores to the data memory, stalls the
// pipe while the memory is busy, extracts/extends load data and registers
// the MEM/WB fields.
//   clk, rst_n        : clock, async active-low reset
//   alu_result_in ... : EX/MEM fields (address/result, store data, rd, control)
//   dmem              : data-memory bus (master side)
//   wb_result, rd_out, reg_write_out, valid_out : MEM/WB register
//   stall_out         : combinational hold request to upstream stages
//   misalign_err      : one-cycle pulse registered with a misaligned access
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  rd_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        valid_in,
  input  logic [2:0]  funct3_in,
  mem_access_if.master dmem,
  output logic [31:0] wb_result,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        valid_out,
  output logic        stall_out,
  output logic        misalign_err
);
  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic        access, misaligned, aligned_acc;
  logic [31:0] byte_sh;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_result_q <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_result_q <= wb_result_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    access      = valid_in & (mem_read_in | mem_write_in);
    misaligned  = 1'b0;
    case (funct3_in[1:0])
      2'b01:   misaligned = alu_result_in[0];
      2'b10:   misaligned = |alu_result_in[1:0];
      default: misaligned = 1'b0;
    endcase
    misaligned  = misaligned & access;
    aligned_acc = access & ~misaligned;

    // Load lane extraction: bytes by addr[1:0], halves by addr[1].
    byte_sh  = dmem.dmem_rdata >> {alu_result_in[1:0], 3'b000};
    half_sel = alu_result_in[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (funct3_in)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_val = {24'h0, byte_sh[7:0]};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = dmem.dmem_rdata;
    endcase

    // Bus outputs depend only on the (held-stable) inputs, so WAIT presents
    // exactly what IDLE presented. Request is masked while reset is held.
    dmem.dmem_req   = aligned_acc & rst_n;
    dmem.dmem_we    = mem_write_in;
    dmem.dmem_addr  = {alu_result_in[31:2], 2'b00};
    dmem.dmem_be    = 4'b0000;
    dmem.dmem_wdata = rs2_data_in;
    if (mem_write_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          dmem.dmem_be    = 4'b0001 << alu_result_in[1:0];
          dmem.dmem_wdata = {4{rs2_data_in[7:0]}};
        end
        2'b01: begin
          dmem.dmem_be    = 4'b0011 << alu_result_in[1:0];
          dmem.dmem_wdata = {2{rs2_data_in[15:0]}};
        end
        default: dmem.dmem_be = 4'b1111;
      endcase
    end

    stall_out = aligned_acc & ~dmem.dmem_ready;

    state_d = state_q;
    case (state_q)
      IDLE:    if (aligned_acc && !dmem.dmem_ready) state_d = WAIT;
      WAIT:    if (dmem.dmem_ready || !aligned_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Default: bubble, holding the last result/rd for forwarding.
    wb_result_d = wb_result_q;
    rd_d        = rd_q;
    reg_write_d = 1'b0;
    valid_d     = 1'b0;
    misalign_d  = 1'b0;
    if (valid_in) begin
      if (!access) begin
        wb_result_d = alu_result_in;
        rd_d        = rd_in;
        reg_write_d = reg_write_in;
        valid_d     = 1'b1;
      end else if (misaligned) begin
        // Retire as a non-writing instruction and flag it.
        wb_result_d = alu_result_in;
        rd_d        = rd_in;
        valid_d     = 1'b1;
        misalign_d  = 1'b1;
      end else if (dmem.dmem_ready) begin
        wb_result_d = mem_to_reg_in ? load_val : alu_result_in;
        rd_d        = rd_in;
        reg_write_d = reg_write_in;
        valid_d     = 1'b1;
      end
    end
  end

  assign wb_result     = wb_result_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q;
  assign valid_out     = valid_q;
  assign misalign_err  = misalign_q;
endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_result_in = '0, rs2_data_in = '0;
  logic [4:0]  rd_in = '0;
  logic        mem_read_in = 0, mem_write_in = 0, reg_write_in = 0, mem_to_reg_in = 0, valid_in = 0;
  logic [2:0]  funct3_in = '0;
  logic [31:0] wb_result;
  logic [4:0]  rd_out;
  logic        reg_write_out, valid_out, stall_out, misalign_err;

  mem_access_if bus ();

  mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in), .rd_in(rd_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .valid_in(valid_in), .funct3_in(funct3_in),
    .dmem(bus.master),
    .wb_result(wb_result), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .valid_out(valid_out), .stall_out(stall_out), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic        chk_wb;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every retired MEM/WB entry is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire: got rd %0d wb 0x%08h expected none", rd_out, wb_result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.chk_wb) chk("wb_result", wb_result, e.wb);
          chk("rd_out", {27'h0, rd_out}, {27'h0, e.rd});
          chk("reg_write_out", {31'h0, reg_write_out}, {31'h0, e.rw});
          chk("misalign_err", {31'h0, misalign_err}, {31'h0, e.mis});
        end
      end else begin
        chk("misalign_idle", {31'h0, misalign_err}, 32'h0);
      end
    end
  end

  task automatic idle();
    valid_in = 0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
    bus.dmem_ready = 0;
  endtask

  // One instruction: lat = memory wait cycles before ready (0 = same cycle).
  task automatic run(input logic mr, mw, rw, m2r, input logic [2:0] f3,
                     input logic [31:0] alu, rs2, rdata, input logic [4:0] rd,
                     input int lat, input logic [3:0] e_be, input logic [31:0] e_wd,
                     input logic [31:0] e_wb, input logic chk_wb, e_rw, e_mis);
    exp_t e;
    logic e_req;
    e.wb = e_wb; e.chk_wb = chk_wb; e.rd = rd; e.rw = e_rw; e.mis = e_mis;
    exp_q.push_back(e);
    e_req = (mr | mw) & ~e_mis;
    @(posedge clk); #1;
    valid_in = 1; mem_read_in = mr; mem_write_in = mw; reg_write_in = rw; mem_to_reg_in = m2r;
    funct3_in = f3; alu_result_in = alu; rs2_data_in = rs2; rd_in = rd;
    bus.dmem_rdata = rdata; bus.dmem_ready = (lat == 0);
    for (int c = 0; c <= lat; c++) begin
      #3;
      chk("stall_out", {31'h0, stall_out}, {31'h0, (e_req && c < lat)});
      chk("dmem_req", {31'h0, bus.dmem_req}, {31'h0, e_req});
      if (e_req) begin
        chk("dmem_addr", bus.dmem_addr, {alu[31:2], 2'b00});
        chk("dmem_be", {28'h0, bus.dmem_be}, {28'h0, e_be});
        if (mw) chk("dmem_wdata", bus.dmem_wdata, e_wd);
      end
      if (c >= 1) chk("bubble_valid", {31'h0, valid_out}, 32'h0);
      if (c < lat) begin
        @(posedge clk); #1;
        bus.dmem_ready = (c + 1 == lat);
      end
    end
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.dmem_ready = 0; bus.dmem_rdata = '0;
    #12;
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_wb", wb_result, 32'h0);
    chk("rst_req", {31'h0, bus.dmem_req}, 32'h0);
    @(negedge clk); rst_n = 1;

    //   mr mw rw m2r f3      alu           rs2           rdata         rd lat be       wdata         exp_wb       cw rw mis
    run(1, 0, 1, 1, 3'b000, 32'h103,      32'h0,        32'h80FF_1234, 5, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1, 1, 0); // LB
    run(0, 1, 0, 0, 3'b001, 32'h202,      32'h0000_ABCD, 32'h0,       6, 3, 4'b1100, 32'hABCD_ABCD, 32'h202,       1, 0, 0); // SH wait 3
    run(1, 0, 1, 1, 3'b010, 32'h106,      32'h0,        32'h0,         7, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 1); // LW misaligned
    run(1, 0, 1, 1, 3'b101, 32'h10,       32'h0,        32'h0000_8001, 8, 0, 4'b0000, 32'h0,        32'h0000_8001, 1, 1, 0); // LHU
    run(1, 0, 1, 1, 3'b001, 32'h10,       32'h0,        32'h0000_8001, 9, 0, 4'b0000, 32'h0,        32'hFFFF_8001, 1, 1, 0); // LH
    run(0, 0, 1, 0, 3'b000, 32'h55,       32'h0,        32'h0,        10, 0, 4'b0000, 32'h0,        32'h55,        1, 1, 0); // ADD
    run(1, 0, 1, 1, 3'b100, 32'h101,      32'h0,        32'h80FF_1234, 11, 0, 4'b0000, 32'h0,       32'h12,        1, 1, 0); // LBU
    run(0, 1, 0, 0, 3'b000, 32'h3,        32'h1234_56A7, 32'h0,       12, 0, 4'b1000, 32'hA7A7_A7A7, 32'h3,        1, 0, 0); // SB
    run(0, 1, 0, 0, 3'b010, 32'h40,       32'hDEAD_BEEF, 32'h0,       13, 0, 4'b1111, 32'hDEAD_BEEF, 32'h40,       1, 0, 0); // SW
    run(1, 0, 1, 1, 3'b010, 32'h44,       32'h0,        32'hCAFE_F00D, 14, 1, 4'b0000, 32'h0,       32'hCAFE_F00D, 1, 1, 0); // LW wait 1
    run(0, 1, 0, 0, 3'b001, 32'h201,      32'h1111,     32'h0,        15, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 1); // SH misaligned
    run(1, 0, 1, 1, 3'b001, 32'h12,       32'h0,        32'h8001_7FFF, 16, 0, 4'b0000, 32'h0,       32'hFFFF_8001, 1, 1, 0); // LH upper half
    run(1, 0, 1, 0, 3'b010, 32'h80,       32'h0,        32'h1234_5678, 17, 0, 4'b0000, 32'h0,       32'h80,        1, 1, 0); // load, mem_to_reg=0

    // Reset in the middle of a WAIT: access abandoned, nothing retires later.
    @(posedge clk); #1;
    valid_in = 1; mem_write_in = 1; funct3_in = 3'b010; alu_result_in = 32'h300;
    rs2_data_in = 32'h77; rd_in = 5'd20; bus.dmem_ready = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rstw_req", {31'h0, bus.dmem_req}, 32'h0);
    chk("rstw_valid", {31'h0, valid_out}, 32'h0);
    chk("rstw_wb", wb_result, 32'h0);
    chk("rstw_rd", {27'h0, rd_out}, 32'h0);
    chk("rstw_rw", {31'h0, reg_write_out}, 32'h0);
    chk("rstw_mis", {31'h0, misalign_err}, 32'h0);
    idle();
    bus.dmem_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    #4;
    chk("post_rst_valid", {31'h0, valid_out}, 32'h0);
    chk("post_rst_wb", wb_result, 32'h0);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, byte-addressed.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 alu_result_in  in  32  EX result; memory byte address for loads/stores, writeback value otherwise.
REQ-005 rs2_data_in  in  32  forwarded store data.
REQ-006 rd_in  in  5  destination register.
REQ-007 mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in, valid_in  in  1 each  EX/MEM control bits.
REQ-008 funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 dmem_req  out  1  data-memory request, held until accepted.
REQ-010 dmem_we  out  1  1 = store, 0 = load.
REQ-011 dmem_addr  out  32  alu_result_in with bits [1:0] forced to 0.
REQ-012 dmem_wdata  out  32  lane-replicated store data.
REQ-013 dmem_be  out  4  byte enables; 0000 on loads.
REQ-014 dmem_ready  in  1  memory accepts/completes the access this cycle.
REQ-015 dmem_rdata  in  32  load word, valid when dmem_ready=1.
REQ-016 wb_result  out  32  registered MEM/WB value; also the MEM/WB forwarding source.
REQ-017 rd_out  out  5, reg_write_out  out  1, valid_out  out  1  registered MEM/WB fields.
REQ-018 stall_out  out  1  combinational; 1 = upstream holds all inputs stable.
REQ-019 misalign_err  out  1  registered one-cycle pulse for a misaligned access.

Function
REQ-020 An access exists when valid_in=1 and (mem_read_in or mem_write_in) is 1.
REQ-021 Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=00.
REQ-022 FSM states are IDLE and WAIT.
REQ-023 IDLE with an aligned access: dmem_req=1 in the same cycle. If dmem_ready=1, the access completes this cycle. Otherwise the FSM moves to WAIT.
REQ-024 WAIT: dmem_req=1 with unchanged addr, we, be and wdata. On dmem_ready=1 the access completes and the FSM returns to IDLE. There is no timeout.
REQ-025 stall_out = aligned access present and dmem_ready=0, in both IDLE and WAIT; one-cycle accesses never stall.
REQ-026 On every stall cycle the MEM/WB register loads a bubble: valid_out=0 and reg_write_out=0.
REQ-027 Completion edge: wb_result = load value if mem_to_reg_in=1, else alu_result_in; reg_write_out=reg_write_in; rd_out=rd_in; valid_out=1.
REQ-028 Non-access instructions (valid_in=1, no read/write): registered in one cycle with wb_result=alu_result_in, and no dmem_req.
REQ-029 valid_in=0: registers a bubble; dmem_req=0.
REQ-030 Load extraction by byte lane addr[1:0] (H uses addr[1]). B/H sign-extend, BU/HU zero-extend, W passes the word.
REQ-031 Store byte enables:
- SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
- SH: be = 0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
- SW: be = 1111, wdata = rs2.
REQ-032 Misaligned access:
- dmem_req stays 0 and there is no stall.
- Registers valid_out=1 with reg_write_out=0.
- misalign_err=1 for one cycle.
REQ-033 misalign_err=0 in all other cycles.
REQ-034 Stores complete with reg_write_out=reg_write_in, which is 0 for legal stores.

Reset
REQ-035 rst_n=0 (async) sets FSM to IDLE and clears wb_result, rd_out, reg_write_out, valid_out and misalign_err to 0. dmem_req is 0 while reset is held.
REQ-036 Reset asserted during WAIT abandons the access. No completion is registered after rst_n rises.

Verification
REQ-037 LB addr 0x103, rdata 0x80FF_1234, ready same cycle -> no stall; next edge wb_result=0xFFFF_FF80, reg_write_out=1.
REQ-038 SH addr 0x202, rs2 0x0000_ABCD, ready after 3 cycles -> stall_out=1 for 3 cycles; dmem_be=1100 and dmem_wdata=0xABCD_ABCD throughout; 3 bubbles, then valid_out=1.
REQ-039 LW addr 0x106 -> dmem_req=0; misalign_err=1 for one cycle; reg_write_out=0; stall_out=0.
REQ-040 LHU addr 0x10, rdata 0x0000_8001 -> wb_result=0x0000_8001; LH at the same address -> 0xFFFF_8001.
REQ-041 ADD result 0x55 with no memory op -> wb_result=0x55 the next cycle; dmem_req never asserted.
REQ-042 rst_n=0 mid-WAIT -> FSM IDLE, dmem_req=0, all outputs 0; no completion after release.
